// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: arbitrates CPU, video and a clear sweep onto one registered single-port RAM.
module ram_port_ctrl #(
  parameter int data_width = 8,
  parameter int address_width = 8,
  parameter logic [data_width-1:0] clear_value = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [address_width-1:0] cpu_addr,
  input  logic [data_width-1:0]    cpu_wdata,
  output logic                     cpu_ack,
  output logic [data_width-1:0]    cpu_rdata,
  input  logic                     vid_req,
  input  logic [address_width-1:0] vid_addr,
  output logic                     vid_valid,
  output logic [data_width-1:0]    vid_rdata,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic [address_width-1:0] ram_address,
  output logic [data_width-1:0]    ram_data,
  output logic                     ram_we,
  input  logic [data_width-1:0]    ram_q
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [address_width-1:0] clr_cnt;
  logic clearing, issue_vid, issue_cpu;
  logic s1_cpu, s1_vid, s2_cpu, s2_vid;
  always_comb begin
    clearing = state == CLEAR;
    issue_vid = !clearing && vid_req;
    issue_cpu = !clearing && !vid_req && cpu_req && !s1_cpu && !s2_cpu;
    state_n = clearing ? (&clr_cnt ? RUN : CLEAR) : (clear_start ? CLEAR : RUN);
  end
  always_ff @(posedge clock)
    if (reset) state <= CLEAR;
    else state <= state_n;
  // s1/s2 tag the access on the RAM bus and the one whose data is on ram_q
  always_ff @(posedge clock) begin
    if (reset) begin
      clr_cnt     <= '0;
      clear_busy  <= 1'b1;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_data    <= '0;
      s1_cpu      <= 1'b0;
      s1_vid      <= 1'b0;
      s2_cpu      <= 1'b0;
      s2_vid      <= 1'b0;
      cpu_ack     <= 1'b0;
      vid_valid   <= 1'b0;
      cpu_rdata   <= '0;
      vid_rdata   <= '0;
    end else begin
      clr_cnt     <= clearing ? clr_cnt + 1'b1 : '0;
      clear_busy  <= clearing;
      ram_we      <= clearing || (issue_cpu && cpu_we);
      ram_address <= clearing ? clr_cnt : issue_vid ? vid_addr : issue_cpu ? cpu_addr : ram_address;
      ram_data    <= clearing ? clear_value : issue_cpu ? cpu_wdata : ram_data;
      s1_cpu      <= issue_cpu;
      s1_vid      <= issue_vid;
      s2_cpu      <= s1_cpu;
      s2_vid      <= s1_vid;
      cpu_ack     <= s2_cpu;
      vid_valid   <= s2_vid;
      cpu_rdata   <= s2_cpu ? ram_q : cpu_rdata;
      vid_rdata   <= s2_vid ? ram_q : vid_rdata;
    end
  end
endmodule

// File: doc/ram_port_ctrl.md
RAM_PORT_CTRL -- requirements
Module: ram_port_ctrl

Interface
REQ-001 SHALL have parameter data_width, default 8, meaning RAM word width.
REQ-002 SHALL have parameter address_width, default 8, meaning RAM address width (depth 2**address_width).
REQ-003 SHALL have parameter clear_value, default 0, meaning word written to every location during a clear sweep.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clock  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have: cpu_req  in  1  CPU access request, held until cpu_ack.
REQ-007 SHALL have: cpu_we  in  1  1 = write, 0 = read; held with cpu_req.
REQ-008 SHALL have: cpu_addr  in  address_width  CPU address; held with cpu_req.
REQ-009 SHALL have: cpu_wdata  in  data_width  CPU write data; held with cpu_req.
REQ-010 SHALL have: cpu_ack  out  1  one-cycle completion pulse.
REQ-011 SHALL have: cpu_rdata  out  data_width  read data, or echoed write data, valid while cpu_ack=1.
REQ-012 SHALL have: vid_req  in  1  video read request; single-cycle, may repeat every cycle.
REQ-013 SHALL have: vid_addr  in  address_width  video address, sampled with vid_req.
REQ-014 SHALL have: vid_valid  out  1  one-cycle pulse per served video read.
REQ-015 SHALL have: vid_rdata  out  data_width  video read data, valid while vid_valid=1.
REQ-016 SHALL have: clear_start  in  1  pulse to start a clear sweep.
REQ-017 SHALL have: clear_busy  out  1  high while a clear sweep is in progress.
REQ-018 SHALL have: ram_address  out  address_width  address to the single-port RAM.
REQ-019 SHALL have: ram_data  out  data_width  write data to the RAM.
REQ-020 SHALL have: ram_we  out  1  RAM write enable.
REQ-021 SHALL have: ram_q  in  data_width  RAM output: registered, one-cycle latency, returns written data on a write cycle.

Function
REQ-022 SHALL drive ram_address, ram_data and ram_we from registers; a request sampled at edge E0 appears on the ram_* outputs during E0..E1.
REQ-023 SHALL register ram_q at E2 into cpu_rdata or vid_rdata, and SHALL pulse cpu_ack or vid_valid during E2..E3; total latency is 2 edges.
REQ-024 SHALL implement FSM states CLEAR and RUN; CLEAR->RUN after the write to address 2**address_width-1; RUN->CLEAR on clear_start=1 sampled at an edge.
REQ-025 In CLEAR, SHALL issue one write per cycle: ram_we=1, ram_data=clear_value, ram_address counting 0 up to 2**address_width-1 with no wrap and no repeats.
REQ-026 SHALL assert clear_busy exactly while the state is CLEAR; it SHALL fall on the edge after the last clear write is issued.
REQ-027 SHALL ignore clear_start while in CLEAR.
REQ-028 In RUN, at each edge, SHALL issue a video read if vid_req=1; else SHALL issue the CPU access if cpu_req=1 and no CPU access is in flight; else ram_we=0.
REQ-029 Video SHALL have absolute priority over CPU; a pending CPU request SHALL wait and never be dropped.
REQ-030 SHALL treat a CPU access as in flight from its issue edge through the edge that raises cpu_ack; cpu_req sampled during that window SHALL NOT re-issue.
REQ-031 SHALL treat cpu_req=1 sampled at the edge ending the cpu_ack cycle as a new request (max CPU rate: one access per 3 cycles).
REQ-032 On a CPU write, SHALL assert ram_we=1 for exactly one cycle and SHALL return the written data on cpu_rdata with cpu_ack.
REQ-033 SHALL serve video reads fully pipelined, one per cycle, with vid_valid pulses in the same order and spacing as the vid_req pulses.
REQ-034 SHALL drop vid_req while in CLEAR: no vid_valid is produced for it.
REQ-035 SHALL hold an unissued CPU request during CLEAR and serve it after clear_busy falls.
REQ-036 Accesses issued before the RUN->CLEAR transition SHALL still complete, with their ack/valid pulses.

Reset
REQ-037 While reset=1: state=CLEAR, clear counter=0, clear_busy=1, ram_we=0, ram_address=0, ram_data=0, cpu_ack=0, vid_valid=0, cpu_rdata=0, vid_rdata=0, no access in flight.
REQ-038 The first clear write (address 0) SHALL be issued in the first cycle after reset deasserts.
REQ-039 Reset asserted mid-sweep SHALL abort the sweep and restart it from address 0 after release; in-flight accesses SHALL be discarded without ack/valid.

Verification
REQ-040 Release reset with address_width=8 -> 256 consecutive cycles of ram_we=1 at addresses 0x00..0xFF with data 0x00, clear_busy high, then clear_busy=0 and ram_we=0.
REQ-041 CPU write 0x5A to 0x10 at E0 -> ram_we=1, addr 0x10, data 0x5A in E0..E1; cpu_ack=1 with cpu_rdata=0x5A in E2..E3; a following read of 0x10 -> cpu_ack with 0x5A.
REQ-042 vid_req on 4 consecutive edges at addresses 0..3 (preloaded 0xA0..0xA3) -> vid_valid on 4 consecutive cycles from E2, data 0xA0..0xA3.
REQ-043 cpu_req and vid_req both high at E0, vid_req low at E1 -> video issued at E0, CPU issued at E1, cpu_ack in E3..E4.
REQ-044 clear_start with cpu_req pending and vid_req pulses during the sweep -> no vid_valid; cpu_ack 2 edges after clear_busy falls.
REQ-045 Reset asserted while ram_address=0x80 in CLEAR -> after release, the sweep restarts at 0x00 and runs a full 256 cycles.
